// File: rtl/alu_pkg.sv
// Shared types and constants for the 32-bit registered ALU.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        EQU  = 4'd0,
        LT   = 4'd1,
        LTU  = 4'd2,
        GT   = 4'd3,
        GTU  = 4'd4,
        ADD  = 4'd5,
        ADDU = 4'd6,
        SUBU = 4'd7,
        SLL  = 4'd8,
        SRL  = 4'd9,
        SRA  = 4'd10,
        OR   = 4'd11,
        XOR  = 4'd12,
        AND  = 4'd13
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic v;
        logic c;
        logic n;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU core: compares, add/sub with carry-in, shifts, bitwise logic.
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nb;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result = '0;
        flags  = '0;
        sum    = '0;
        nb     = '0;
        case (op)
            EQU: flags.z = (a == b);
            LT:  flags.z = ($signed(a) < $signed(b));
            LTU: flags.z = (a < b);
            GT:  flags.z = ($signed(a) > $signed(b));
            GTU: flags.z = (a > b);
            ADD, ADDU: begin
                sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                result  = sum[WIDTH-1:0];
                flags.c = sum[WIDTH];
                flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            SUBU: begin
                // Two's complement of B is truncated, so B=0 contributes no carry.
                nb      = ~b + 1'b1;
                sum     = {1'b0, a} + {1'b0, nb} + {{WIDTH{1'b0}}, cin};
                result  = sum[WIDTH-1:0];
                flags.c = sum[WIDTH];
                flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            SLL: result = a << b[4:0];
            SRL: result = a >> b[4:0];
            SRA: result = $signed(a) >>> b[4:0];
            OR:  result = a | b;
            XOR: result = a ^ b;
            AND: result = a & b;
            default: result = '0;
        endcase
        flags.n = result[WIDTH-1];
    end

endmodule

// File: rtl/alu32_reg.sv
// Registered 32-bit ALU. Define ALU_INPUT_REG_EN to add the input register stage
// (latency 2); otherwise only the output register is present (latency 1).
module alu32_reg
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A_top,
    input  logic [31:0] B_top,
    input  logic [3:0]  Alu_Cntrl_top,
    input  logic        Cin_top,
    output logic        Zero_top,
    output logic        oVerflow_top,
    output logic        Carry_top,
    output logic        Negative_top,
    output logic [31:0] OUT_top
);

    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [3:0]       core_op;
    logic             core_cin;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

`ifdef ALU_INPUT_REG_EN
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic [3:0]       op_d, op_q;
    logic             cin_d, cin_q;

    always_comb begin
        a_d   = A_top;
        b_d   = B_top;
        op_d  = Alu_Cntrl_top;
        cin_d = Cin_top;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cin_q <= cin_d;
        end
    end

    assign core_a   = a_q;
    assign core_b   = b_q;
    assign core_op  = op_q;
    assign core_cin = cin_q;
`else
    assign core_a   = A_top;
    assign core_b   = B_top;
    assign core_op  = Alu_Cntrl_top;
    assign core_cin = Cin_top;
`endif

    alu_core u_core (
        .a      (core_a),
        .b      (core_b),
        .op     (core_op),
        .cin    (core_cin),
        .result (core_result),
        .flags  (core_flags)
    );

    logic [WIDTH-1:0] out_d, out_q;
    alu_flags_t       flags_d, flags_q;

    always_comb begin
        out_d   = core_result;
        flags_d = core_flags;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign OUT_top      = out_q;
    assign Zero_top     = flags_q.z;
    assign oVerflow_top = flags_q.v;
    assign Carry_top    = flags_q.c;
    assign Negative_top = flags_q.n;

endmodule

// File: tb/tb_alu32_reg.sv
// Scoreboard bench for alu32_reg: expected results queued at issue, compared when due.
module tb_alu32_reg;

`ifdef ALU_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A_top, B_top;
    logic [3:0]  Alu_Cntrl_top;
    logic        Cin_top;
    logic        Zero_top, oVerflow_top, Carry_top, Negative_top;
    logic [31:0] OUT_top;

    alu32_reg dut (
        .clk           (clk),
        .reset         (reset),
        .A_top         (A_top),
        .B_top         (B_top),
        .Alu_Cntrl_top (Alu_Cntrl_top),
        .Cin_top       (Cin_top),
        .Zero_top      (Zero_top),
        .oVerflow_top  (oVerflow_top),
        .Carry_top     (Carry_top),
        .Negative_top  (Negative_top),
        .OUT_top       (OUT_top)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic [3:0]  flags;  // {z, v, c, n}
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] dut_flags();
        return {Zero_top, oVerflow_top, Carry_top, Negative_top};
    endfunction

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.tag, ".out"}, OUT_top, e.out);
            check({e.tag, ".zvcn"}, {28'd0, dut_flags()}, {28'd0, e.flags});
        end
    endtask

    // One cycle: retire whatever is due, then issue a new operation.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic cin,
                        input logic [31:0] exp_out, input logic [3:0] exp_flags);
        exp_t e;
        @(negedge clk);
        cyc++;
        check_due();
        A_top = a; B_top = b; Alu_Cntrl_top = op; Cin_top = cin;
        e.tag = tag; e.out = exp_out; e.flags = exp_flags; e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        cyc++;
        check_due();
    endtask

    initial begin
        reset = 1'b1;
        A_top = '0; B_top = '0; Alu_Cntrl_top = '0; Cin_top = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.out", OUT_top, 32'h0);
        check("reset.zvcn", {28'd0, dut_flags()}, 32'h0);
        reset = 1'b0;

        // Compares: R=0, only Z may be set
        step("equ_eq",    32'h0A0A0A0A, 32'h0A0A0A0A, 4'd0, 1'b0, 32'h0, 4'b1000);
        step("lt_eq",     32'h0A0A0A0A, 32'h0A0A0A0A, 4'd1, 1'b0, 32'h0, 4'b0000);
        step("lt_neg",    32'hFFFFFFFF, 32'h00000001, 4'd1, 1'b0, 32'h0, 4'b1000);
        step("ltu_big",   32'hFFFFFFFF, 32'h00000001, 4'd2, 1'b0, 32'h0, 4'b0000);
        step("gtu_big",   32'hFFFFFFFF, 32'h00000001, 4'd4, 1'b0, 32'h0, 4'b1000);
        step("gt_neg",    32'hFFFFFFFF, 32'h00000001, 4'd3, 1'b0, 32'h0, 4'b0000);
        step("equ_ne",    32'h00000001, 32'h00000002, 4'd0, 1'b0, 32'h0, 4'b0000);
        step("ltu_small", 32'h00000001, 32'hFFFFFFFF, 4'd2, 1'b0, 32'h0, 4'b1000);
        step("gtu_eq",    32'h00000000, 32'h00000000, 4'd4, 1'b0, 32'h0, 4'b0000);
        step("gt_pos",    32'h00000001, 32'hFFFFFFFF, 4'd3, 1'b0, 32'h0, 4'b1000);
        // Add / sub
        step("add_ovf",   32'h7FFFFFFF, 32'h00000000, 4'd5, 1'b1, 32'h80000000, 4'b0101);
        step("addu_wrap", 32'hFFFFFFFF, 32'h00000001, 4'd6, 1'b0, 32'h00000000, 4'b0010);
        step("addu_cin",  32'hFFFFFFFF, 32'h00000000, 4'd6, 1'b1, 32'h00000000, 4'b0010);
        step("subu_c0",   32'h00000005, 32'h00000003, 4'd7, 1'b0, 32'h00000002, 4'b0010);
        step("subu_c1",   32'h00000005, 32'h00000003, 4'd7, 1'b1, 32'h00000003, 4'b0010);
        step("subu_neg",  32'h00000003, 32'h00000005, 4'd7, 1'b0, 32'hFFFFFFFE, 4'b0001);
        step("subu_b0",   32'h00000007, 32'h00000000, 4'd7, 1'b0, 32'h00000007, 4'b0000);
        step("subu_ovf",  32'h80000000, 32'h00000001, 4'd7, 1'b0, 32'h7FFFFFFF, 4'b0110);
        // Shifts
        step("sll_out",   32'h80000000, 32'h00000004, 4'd8,  1'b0, 32'h00000000, 4'b0000);
        step("srl",       32'h80000000, 32'h00000004, 4'd9,  1'b0, 32'h08000000, 4'b0000);
        step("sra",       32'h80000000, 32'h00000004, 4'd10, 1'b0, 32'hF8000000, 4'b0001);
        step("srl_b25",   32'h80000000, 32'h00000025, 4'd9,  1'b0, 32'h04000000, 4'b0000);
        step("sra_b25",   32'h80000000, 32'h00000025, 4'd10, 1'b0, 32'hFC000000, 4'b0001);
        step("sll_b25",   32'h00000001, 32'h00000025, 4'd8,  1'b1, 32'h00000020, 4'b0000);
        // Bitwise and reserved
        step("or",        32'hF0F0F0F0, 32'h0F0F0000, 4'd11, 1'b0, 32'hFFFFF0F0, 4'b0001);
        step("xor",       32'hFFFF0000, 32'h0F0F0F0F, 4'd12, 1'b0, 32'hF0F00F0F, 4'b0001);
        step("and",       32'hFFFF0000, 32'h0F0F0F0F, 4'd13, 1'b0, 32'h0F0F0000, 4'b0000);
        step("and_zero",  32'hF0F0F0F0, 32'h0F0F0F0F, 4'd13, 1'b0, 32'h00000000, 4'b0000);
        step("rsv14",     32'hFFFFFFFF, 32'hFFFFFFFF, 4'd14, 1'b1, 32'h00000000, 4'b0000);
        step("rsv15",     32'hFFFFFFFF, 32'h00000001, 4'd15, 1'b1, 32'h00000000, 4'b0000);

        // Mid-stream reset: anything still in flight is discarded
        step("pre_rst",   32'h00000001, 32'h00000001, 4'd5, 1'b0, 32'h00000002, 4'b0000);
        @(negedge clk);
        cyc++;
        check_due();
        A_top = 32'hFFFFFFFF; B_top = 32'h00000001; Alu_Cntrl_top = 4'd6; Cin_top = 1'b1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        cyc++;
        check("midrst.out", OUT_top, 32'h0);
        check("midrst.zvcn", {28'd0, dut_flags()}, 32'h0);
        reset = 1'b0;

        step("post_rst",  32'h00000010, 32'h00000001, 4'd11, 1'b0, 32'h00000011, 4'b0000);
        step("post_sub",  32'h00000000, 32'h00000001, 4'd7,  1'b0, 32'hFFFFFFFF, 4'b0001);

        for (int i = 0; i < 10 && sb.size() > 0; i++) idle();
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
